// File: rtl/fifo_pause.sv
// Synchronous FIFO with registered pop data, occupancy count and flow-control flags.
// almost_full is the pause signal back to the producer; error latches any overflow/underflow.
module fifo_pause #(
  parameter int DATA_WIDTH   = 6,
  parameter int ADDR_WIDTH   = 3,
  parameter int ALMOST_FULL  = 6,
  parameter int ALMOST_EMPTY = 1
) (
  input  logic                  clk,
  input  logic                  reset_L,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  push,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   count
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_LVL = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_LVL    = (ADDR_WIDTH + 1)'(ALMOST_FULL);
  localparam logic [ADDR_WIDTH:0] AE_LVL    = (ADDR_WIDTH + 1)'(ALMOST_EMPTY);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic                  rd_ok;
  logic                  wr_ok;
  logic                  overflow;
  logic                  underflow;

  assign full         = (count == DEPTH_LVL);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AF_LVL);
  assign almost_empty = (count <= AE_LVL);

  // A pop frees a slot in the same edge, so a full FIFO still accepts push+pop.
  assign rd_ok     = pop && !empty;
  assign wr_ok     = push && (!full || rd_ok);
  assign overflow  = push && full && !pop;
  assign underflow = pop && empty;

  // NOTE: the storage array has no reset; its contents are meaningless until
  // written, and leaving it out keeps it mappable to plain flops or RAM.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= data_in;
  end

  // NOTE: all state here uses non-blocking assignments so every register sees
  // the pre-edge values of the others, regardless of statement order.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
      error     <= 1'b0;
    end else begin
      valid_out <= rd_ok;
      if (rd_ok) begin
        data_out <= mem[rd_ptr];
        rd_ptr   <= rd_ptr + 1'b1;
      end
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (overflow || underflow) error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_pause.sv
// Directed self-checking bench for fifo_pause: ordering, thresholds, overflow,
// underflow, full push+pop with wrap-around, and asynchronous reset.
module tb_fifo_pause;

  logic       clk = 1'b0;
  logic       reset_L;
  logic [5:0] data_in;
  logic       push;
  logic       pop;
  logic [5:0] data_out;
  logic       valid_out;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic       error;
  logic [3:0] count;

  int passed = 0;
  int total  = 0;

  fifo_pause dut (
    .clk          (clk),
    .reset_L      (reset_L),
    .data_in      (data_in),
    .push         (push),
    .pop          (pop),
    .data_out     (data_out),
    .valid_out    (valid_out),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .error        (error),
    .count        (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " data_out"},     32'(data_out), 32'h0);
    check({tag, " valid_out"},    32'(valid_out), 32'h0);
    check({tag, " empty"},        32'(empty), 32'h1);
    check({tag, " almost_empty"}, 32'(almost_empty), 32'h1);
    check({tag, " full"},         32'(full), 32'h0);
    check({tag, " almost_full"},  32'(almost_full), 32'h0);
    check({tag, " error"},        32'(error), 32'h0);
    check({tag, " count"},        32'(count), 32'h0);
  endtask

  task automatic do_reset();
    reset_L = 1'b0;
    push    = 1'b0;
    pop     = 1'b0;
    #3;
    reset_L = 1'b1;
    step();
  endtask

  logic [5:0] exp_words [3];

  initial begin
    reset_L = 1'b0;
    push    = 1'b0;
    pop     = 1'b0;
    data_in = '0;

    // Reset before any clock edge, then one idle cycle after release.
    #2;
    check_reset_state("por");
    @(posedge clk);
    #1;
    reset_L = 1'b1;
    step();
    check_reset_state("idle");

    // Three pushes, three pops: 1-cycle latency, strict order.
    exp_words[0] = 6'h2A;
    exp_words[1] = 6'h2C;
    exp_words[2] = 6'h2E;
    push = 1'b1;
    for (int i = 0; i < 3; i++) begin
      data_in = exp_words[i];
      step();
      check($sformatf("fill3 count %0d", i), 32'(count), 32'(i + 1));
    end
    push = 1'b0;
    check("fill3 valid idle", 32'(valid_out), 32'h0);
    pop = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("pop3 valid %0d", i), 32'(valid_out), 32'h1);
      check($sformatf("pop3 data %0d", i), 32'(data_out), 32'(exp_words[i]));
      check($sformatf("pop3 count %0d", i), 32'(count), 32'(2 - i));
    end
    pop = 1'b0;
    step();
    check("pop3 valid after", 32'(valid_out), 32'h0);
    check("pop3 data held", 32'(data_out), 32'h2E);
    check("pop3 empty", 32'(empty), 32'h1);
    check("pop3 error", 32'(error), 32'h0);

    // Fill to 8: watch thresholds at every level.
    push = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      data_in = 6'(i);
      step();
      check($sformatf("fill8 count %0d", i), 32'(count), 32'(i));
      check($sformatf("fill8 almost_full %0d", i), 32'(almost_full), 32'(i >= 6));
      check($sformatf("fill8 almost_empty %0d", i), 32'(almost_empty), 32'(i <= 1));
      check($sformatf("fill8 full %0d", i), 32'(full), 32'(i == 8));
    end
    data_in = 6'h3F;
    step();
    push = 1'b0;
    check("overflow error", 32'(error), 32'h1);
    check("overflow count", 32'(count), 32'h8);
    check("overflow full", 32'(full), 32'h1);
    pop = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step();
      check($sformatf("drain8 valid %0d", i), 32'(valid_out), 32'h1);
      check($sformatf("drain8 data %0d", i), 32'(data_out), 32'(i));
    end
    pop = 1'b0;
    step();
    check("drain8 valid off", 32'(valid_out), 32'h0);
    check("drain8 empty", 32'(empty), 32'h1);
    check("drain8 error sticky", 32'(error), 32'h1);

    // Full FIFO: push+pop for 4 cycles, then drain across the wrap.
    do_reset();
    check("rst2 error", 32'(error), 32'h0);
    push = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      data_in = 6'(i);
      step();
    end
    check("refill full", 32'(full), 32'h1);
    data_in = 6'h15;
    pop = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step();
      check($sformatf("fullpp data %0d", i), 32'(data_out), 32'(i));
      check($sformatf("fullpp valid %0d", i), 32'(valid_out), 32'h1);
      check($sformatf("fullpp count %0d", i), 32'(count), 32'h8);
      check($sformatf("fullpp full %0d", i), 32'(full), 32'h1);
      check($sformatf("fullpp error %0d", i), 32'(error), 32'h0);
    end
    push = 1'b0;
    for (int i = 5; i <= 12; i++) begin
      step();
      check($sformatf("wrapdrain data %0d", i), 32'(data_out), (i <= 8) ? 32'(i) : 32'h15);
      check($sformatf("wrapdrain valid %0d", i), 32'(valid_out), 32'h1);
    end
    pop = 1'b0;
    step();
    check("wrapdrain empty", 32'(empty), 32'h1);
    check("wrapdrain error", 32'(error), 32'h0);

    // Underflow, then push+pop on empty (no bypass), then read it back.
    pop = 1'b1;
    step();
    check("underflow valid", 32'(valid_out), 32'h0);
    check("underflow count", 32'(count), 32'h0);
    check("underflow error", 32'(error), 32'h1);
    push = 1'b1;
    data_in = 6'h2A;
    step();
    push = 1'b0;
    check("emptypp count", 32'(count), 32'h1);
    check("emptypp valid", 32'(valid_out), 32'h0);
    step();
    pop = 1'b0;
    check("emptypp readback valid", 32'(valid_out), 32'h1);
    check("emptypp readback data", 32'(data_out), 32'h2A);
    check("emptypp readback count", 32'(count), 32'h0);

    // Fill to 5, assert reset between edges: outputs clear with no clock edge.
    do_reset();
    push = 1'b1;
    for (int i = 0; i < 5; i++) begin
      data_in = 6'(6'h31 + i);
      step();
    end
    push = 1'b0;
    pop  = 1'b1;
    step();
    pop  = 1'b0;
    check("pre-async count", 32'(count), 32'h4);
    check("pre-async data", 32'(data_out), 32'h31);
    #2;
    reset_L = 1'b0;
    #1;
    check_reset_state("async");
    #2;
    reset_L = 1'b1;
    pop = 1'b1;
    step();
    pop = 1'b0;
    check("post-async underflow error", 32'(error), 32'h1);
    check("post-async valid", 32'(valid_out), 32'h0);
    check("post-async count", 32'(count), 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
